// File: rtl/mips_exc_pkg.sv
// Shared definitions for the MIPS exception path: Cause.ExcCode values, the
// default exception vector, the exception-controller FSM state encoding, the
// BadVAddr source select, and the EPC helper.
package mips_exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRE,
    ST_DRAIN
  } exc_state_e;

  typedef enum logic [1:0] {
    BADV_NONE,
    BADV_PC,
    BADV_DADDR
  } badv_sel_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Commit-stage / CP0 / fetch bundle of the exception controller.
//   master : the controller (samples MEM flags and CP0 state, drives strobes)
//   slave  : pipeline + CP0 side (drives flags, consumes strobes/redirect)
interface exc_ctrl_if;
  logic        stall_i;
  logic        m_valid_i;
  logic [31:0] m_pc_i;
  logic        m_bd_i;
  logic        m_adel_if_i;
  logic        m_ri_i;
  logic        m_ov_i;
  logic        m_sys_i;
  logic        m_bp_i;
  logic        m_adel_d_i;
  logic        m_ades_d_i;
  logic        m_eret_i;
  logic [31:0] m_daddr_i;
  logic        int_pending_i;
  logic        exl_i;
  logic [31:0] epc_i;

  logic        kill_m_o;
  logic        cp0_exc_we_o;
  logic        cp0_epc_we_o;
  logic        cp0_badv_we_o;
  logic        cp0_eret_o;
  logic [4:0]  exc_code_o;
  logic        exc_bd_o;
  logic [31:0] exc_epc_o;
  logic [31:0] exc_badv_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    input  stall_i, m_valid_i, m_pc_i, m_bd_i, m_adel_if_i, m_ri_i, m_ov_i,
           m_sys_i, m_bp_i, m_adel_d_i, m_ades_d_i, m_eret_i, m_daddr_i,
           int_pending_i, exl_i, epc_i,
    output kill_m_o, cp0_exc_we_o, cp0_epc_we_o, cp0_badv_we_o, cp0_eret_o,
           exc_code_o, exc_bd_o, exc_epc_o, exc_badv_o, flush_o, redirect_o,
           redirect_pc_o, busy_o
  );

  modport slave (
    output stall_i, m_valid_i, m_pc_i, m_bd_i, m_adel_if_i, m_ri_i, m_ov_i,
           m_sys_i, m_bp_i, m_adel_d_i, m_ades_d_i, m_eret_i, m_daddr_i,
           int_pending_i, exl_i, epc_i,
    input  kill_m_o, cp0_exc_we_o, cp0_epc_we_o, cp0_badv_we_o, cp0_eret_o,
           exc_code_o, exc_bd_o, exc_epc_o, exc_badv_o, flush_o, redirect_o,
           redirect_pc_o, busy_o
  );
endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder for commit-stage events (purely combinational).
//   in : interrupt request and the eight MEM-stage exception/eret flags
//   out: valid (some event present), code (ExcCode), badv_sel (BadVAddr
//        source), is_eret (winning event is a plain eret)
module exc_prio_enc
  import mips_exc_pkg::*;
(
  input  logic       int_pending,
  input  logic       adel_if,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
  input  logic       adel_d,
  input  logic       ades_d,
  input  logic       eret,
  output logic       valid,
  output logic [4:0] code,
  output badv_sel_e  badv_sel,
  output logic       is_eret
);

  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    valid    = 1'b1;
    code     = EXC_INT;
    badv_sel = BADV_NONE;
    is_eret  = 1'b0;
    if (int_pending) begin
      code = EXC_INT;
    end else if (adel_if) begin
      code     = EXC_ADEL;
      badv_sel = BADV_PC;
    end else if (ri) begin
      code = EXC_RI;
    end else if (ov) begin
      code = EXC_OV;
    end else if (sys) begin
      code = EXC_SYS;
    end else if (bp) begin
      code = EXC_BP;
    end else if (adel_d) begin
      code     = EXC_ADEL;
      badv_sel = BADV_DADDR;
    end else if (ades_d) begin
      code     = EXC_ADES;
      badv_sel = BADV_DADDR;
    end else if (eret) begin
      is_eret = 1'b1;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / interrupt controller for the 5-stage MIPS core.
// Picks one commit-stage event, kills the committing instruction in the same
// cycle, then for one cycle (FIRE) pulses the CP0 update strobes, flushes
// IF..MEM and redirects fetch; a DRAIN window of DRAIN_CYC cycles follows in
// which the refilling pipeline cannot raise another event.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : exc_ctrl_if.master (MEM flags, CP0 state in; strobes out)
module exc_ctrl
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned DRAIN_CYC  = 2  // 1..15
) (
  input logic         clk,
  input logic         rst,
  exc_ctrl_if.master  bus
);

  exc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       enc_valid;
  logic [4:0] enc_code;
  badv_sel_e  enc_badv_sel;
  logic       enc_eret;
  logic       cand;

  logic        exc_we_q, epc_we_q, badv_we_q, eret_q;
  logic        flush_q, redirect_q, busy_q, bd_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q, badv_q, redirect_pc_q;

  exc_prio_enc u_prio (
    .int_pending (bus.int_pending_i),
    .adel_if     (bus.m_adel_if_i),
    .ri          (bus.m_ri_i),
    .ov          (bus.m_ov_i),
    .sys         (bus.m_sys_i),
    .bp          (bus.m_bp_i),
    .adel_d      (bus.m_adel_d_i),
    .ades_d      (bus.m_ades_d_i),
    .eret        (bus.m_eret_i),
    .valid       (enc_valid),
    .code        (enc_code),
    .badv_sel    (enc_badv_sel),
    .is_eret     (enc_eret)
  );

  // Bubbles never take an event, so a pending interrupt waits for a real
  // instruction to reach MEM; FIRE/DRAIN ignore the inputs entirely.
  assign cand = (state_q == ST_IDLE) && !bus.stall_i && bus.m_valid_i && enc_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:  if (cand) state_d = ST_FIRE;
      ST_FIRE: begin
        state_d = ST_DRAIN;
        cnt_d   = 4'(DRAIN_CYC - 1);
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs: the strobes are high only in the cycle after the
  // candidate, which is exactly the FIRE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_we_q      <= 1'b0;
      epc_we_q      <= 1'b0;
      badv_we_q     <= 1'b0;
      eret_q        <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      busy_q        <= 1'b0;
      code_q        <= EXC_INT;
      bd_q          <= 1'b0;
      epc_q         <= '0;
      badv_q        <= '0;
      redirect_pc_q <= EXC_VECTOR;
    end else begin
      exc_we_q   <= cand && !enc_eret;
      // With EXL already set the handler is nested: keep the original EPC.
      epc_we_q   <= cand && !enc_eret && !bus.exl_i;
      badv_we_q  <= cand && (enc_badv_sel != BADV_NONE);
      eret_q     <= cand && enc_eret;
      flush_q    <= cand;
      redirect_q <= cand;
      busy_q     <= (state_d != ST_IDLE);
      if (cand) begin
        redirect_pc_q <= enc_eret ? bus.epc_i : EXC_VECTOR;
        if (!enc_eret) begin
          code_q <= enc_code;
          bd_q   <= bus.m_bd_i;
          epc_q  <= epc_of(bus.m_pc_i, bus.m_bd_i);
          if (enc_badv_sel != BADV_NONE)
            badv_q <= (enc_badv_sel == BADV_PC) ? bus.m_pc_i : bus.m_daddr_i;
        end
      end
    end
  end

  assign bus.kill_m_o      = cand;
  assign bus.cp0_exc_we_o  = exc_we_q;
  assign bus.cp0_epc_we_o  = epc_we_q;
  assign bus.cp0_badv_we_o = badv_we_q;
  assign bus.cp0_eret_o    = eret_q;
  assign bus.exc_code_o    = code_q;
  assign bus.exc_bd_o      = bd_q;
  assign bus.exc_epc_o     = epc_q;
  assign bus.exc_badv_o    = badv_q;
  assign bus.flush_o       = flush_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl (EXC_VECTOR=0xBFC0_0380,
// DRAIN_CYC=2). Inputs change 1 ns after the rising edge; outputs are
// sampled there too, well away from the next edge.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  exc_ctrl_if bus ();

  exc_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_i       = 1'b0;
    bus.m_valid_i     = 1'b0;
    bus.m_pc_i        = '0;
    bus.m_bd_i        = 1'b0;
    bus.m_adel_if_i   = 1'b0;
    bus.m_ri_i        = 1'b0;
    bus.m_ov_i        = 1'b0;
    bus.m_sys_i       = 1'b0;
    bus.m_bp_i        = 1'b0;
    bus.m_adel_d_i    = 1'b0;
    bus.m_ades_d_i    = 1'b0;
    bus.m_eret_i      = 1'b0;
    bus.m_daddr_i     = '0;
    bus.int_pending_i = 1'b0;
    bus.exl_i         = 1'b0;
    bus.epc_i         = '0;
  endtask

  // Waits (bounded) for the FSM to return to IDLE.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    clear_inputs();
    tick();
    tick();
    // Reset values while rst is held.
    check("rst_busy",    {31'd0, bus.busy_o}, 32'd0);
    check("rst_flush",   {31'd0, bus.flush_o}, 32'd0);
    check("rst_code",    {27'd0, bus.exc_code_o}, 32'd0);
    check("rst_epc",     bus.exc_epc_o, 32'd0);
    check("rst_badv",    bus.exc_badv_o, 32'd0);
    check("rst_rpc",     bus.redirect_pc_o, VEC);
    rst = 1'b0;
    tick();

    // Ov, no delay slot.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0100; bus.m_ov_i = 1'b1;
    #1 check("ov_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("ov_code",    {27'd0, bus.exc_code_o}, 32'd12);
    check("ov_epc",     bus.exc_epc_o, 32'hBFC0_0100);
    check("ov_epc_we",  {31'd0, bus.cp0_epc_we_o}, 32'd1);
    check("ov_exc_we",  {31'd0, bus.cp0_exc_we_o}, 32'd1);
    check("ov_badv_we", {31'd0, bus.cp0_badv_we_o}, 32'd0);
    check("ov_flush",   {31'd0, bus.flush_o}, 32'd1);
    check("ov_redir",   {31'd0, bus.redirect_o}, 32'd1);
    check("ov_rpc",     bus.redirect_pc_o, VEC);
    check("ov_busy",    {31'd0, bus.busy_o}, 32'd1);
    tick();
    check("ov_drain_flush", {31'd0, bus.flush_o}, 32'd0);
    check("ov_drain_busy",  {31'd0, bus.busy_o}, 32'd1);
    tick();
    check("ov_drain2_busy", {31'd0, bus.busy_o}, 32'd1);
    tick();
    check("ov_idle", {31'd0, bus.busy_o}, 32'd0);

    // AdES in a delay slot.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0204; bus.m_bd_i = 1'b1;
    bus.m_ades_d_i = 1'b1; bus.m_daddr_i = 32'h8000_0002;
    #1 check("ades_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("ades_code",    {27'd0, bus.exc_code_o}, 32'd5);
    check("ades_bd",      {31'd0, bus.exc_bd_o}, 32'd1);
    check("ades_epc",     bus.exc_epc_o, 32'hBFC0_0200);
    check("ades_badv",    bus.exc_badv_o, 32'h8000_0002);
    check("ades_badv_we", {31'd0, bus.cp0_badv_we_o}, 32'd1);
    wait_idle("ades_idle");

    // Interrupt beats Sys; Sys held through the drain window.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0300;
    bus.int_pending_i = 1'b1; bus.m_sys_i = 1'b1;
    #1 check("int_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    bus.int_pending_i = 1'b0;
    #1;
    check("int_code",   {27'd0, bus.exc_code_o}, 32'd0);
    check("int_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd1);
    check("fire_kill",  {31'd0, bus.kill_m_o}, 32'd0);
    tick();
    check("drain1_kill",  {31'd0, bus.kill_m_o}, 32'd0);
    check("drain1_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd0);
    tick();
    check("drain2_kill",  {31'd0, bus.kill_m_o}, 32'd0);
    check("drain2_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd0);
    tick();
    check("post_drain_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("sys_code",   {27'd0, bus.exc_code_o}, 32'd8);
    check("sys_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd1);
    wait_idle("sys_idle");

    // eret alone.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0300; bus.m_eret_i = 1'b1;
    bus.epc_i = 32'hBFC0_1234; bus.exl_i = 1'b1;
    #1 check("eret_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("eret_pulse",  {31'd0, bus.cp0_eret_o}, 32'd1);
    check("eret_rpc",    bus.redirect_pc_o, 32'hBFC0_1234);
    check("eret_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd0);
    check("eret_epc_we", {31'd0, bus.cp0_epc_we_o}, 32'd0);
    check("eret_flush",  {31'd0, bus.flush_o}, 32'd1);
    wait_idle("eret_idle");

    // eret with a simultaneous interrupt: the interrupt wins.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0400; bus.m_eret_i = 1'b1;
    bus.epc_i = 32'hBFC0_1234; bus.int_pending_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("eint_code",  {27'd0, bus.exc_code_o}, 32'd0);
    check("eint_epc",   bus.exc_epc_o, 32'hBFC0_0400);
    check("eint_eret",  {31'd0, bus.cp0_eret_o}, 32'd0);
    check("eint_rpc",   bus.redirect_pc_o, VEC);
    wait_idle("eint_idle");

    // eret carrying RI: the exception wins.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0500; bus.m_eret_i = 1'b1;
    bus.m_ri_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("eri_code", {27'd0, bus.exc_code_o}, 32'd10);
    check("eri_eret", {31'd0, bus.cp0_eret_o}, 32'd0);
    wait_idle("eri_idle");

    // AdEL fetch beats RI; BadVAddr is the PC. EXL set suppresses EPC write.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0601; bus.m_adel_if_i = 1'b1;
    bus.m_ri_i = 1'b1; bus.m_daddr_i = 32'h1234_5678; bus.exl_i = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("adel_code",   {27'd0, bus.exc_code_o}, 32'd4);
    check("adel_badv",   bus.exc_badv_o, 32'hBFC0_0601);
    check("adel_epc_we", {31'd0, bus.cp0_epc_we_o}, 32'd0);
    check("adel_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd1);
    wait_idle("adel_idle");

    // Interrupt blocked by stall, then by bubbles.
    bus.int_pending_i = 1'b1; bus.stall_i = 1'b1; bus.m_valid_i = 1'b1;
    bus.m_pc_i = 32'hBFC0_0700;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_kill", {31'd0, bus.kill_m_o}, 32'd0);
      tick();
      check("stall_busy", {31'd0, bus.busy_o}, 32'd0);
    end
    bus.stall_i = 1'b0; bus.m_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check("bubble_kill", {31'd0, bus.kill_m_o}, 32'd0);
      tick();
      check("bubble_busy", {31'd0, bus.busy_o}, 32'd0);
    end
    bus.m_valid_i = 1'b1;
    #1 check("unblock_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("unblock_code", {27'd0, bus.exc_code_o}, 32'd0);
    check("unblock_epc",  bus.exc_epc_o, 32'hBFC0_0700);
    wait_idle("unblock_idle");

    // Reset during FIRE.
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0800; bus.m_sys_i = 1'b1;
    tick();
    clear_inputs();
    #1 check("prerst_flush", {31'd0, bus.flush_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_flush",  {31'd0, bus.flush_o}, 32'd0);
    check("midrst_exc_we", {31'd0, bus.cp0_exc_we_o}, 32'd0);
    check("midrst_redir",  {31'd0, bus.redirect_o}, 32'd0);
    check("midrst_busy",   {31'd0, bus.busy_o}, 32'd0);
    check("midrst_code",   {27'd0, bus.exc_code_o}, 32'd0);
    check("midrst_rpc",    bus.redirect_pc_o, VEC);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_busy", {31'd0, bus.busy_o}, 32'd0);
    bus.m_valid_i = 1'b1; bus.m_pc_i = 32'hBFC0_0900; bus.m_bp_i = 1'b1;
    #1 check("postrst_kill", {31'd0, bus.kill_m_o}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("postrst_code",  {27'd0, bus.exc_code_o}, 32'd9);
    check("postrst_epc",   bus.exc_epc_o, 32'hBFC0_0900);
    check("postrst_flush", {31'd0, bus.flush_o}, 32'd1);
    wait_idle("postrst_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller for the 5-stage MIPS core. It samples the exception flags carried to the memory (commit) stage, picks exactly one event by fixed priority and kills the committing instruction. It then drives a single-cycle update strobe to CP0 (Cause.ExcCode, Cause.BD, EPC, BadVAddr, Status.EXL), flushes IF..MEM and redirects fetch to the exception vector or EPC (eret). A drain window follows so that refilling bubbles cannot raise a second event.

## Interface
- EXC_VECTOR, 32'hBFC0_0380: redirect target for all exceptions and interrupts.
- DRAIN_CYC, 2: cycles after redirect during which commit-stage events are ignored (1..15).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  1  pipeline stall; no event is taken while high.
- m_valid_i  in  1  memory stage holds a real instruction.
- m_pc_i  in  32  PC of memory-stage instruction.
- m_bd_i  in  1  instruction is in a branch delay slot.
- m_adel_if_i, m_ri_i, m_ov_i, m_sys_i, m_bp_i, m_adel_d_i, m_ades_d_i, m_eret_i  in  1 each  exception/eret flags carried to MEM.
- m_daddr_i  in  32  data address of memory-stage load/store.
- int_pending_i  in  1  CP0 interrupt request (IE & ~EXL & |(IM&IP)), computed in CP0.
- exl_i  in  1  current Status.EXL.
- epc_i  in  32  current CP0 EPC.
- kill_m_o  out  1  combinational: suppress write-back/store of the memory-stage instruction this cycle.
- cp0_exc_we_o  out  1  pulse: CP0 updates Cause.ExcCode, Cause.BD, sets EXL.
- cp0_epc_we_o  out  1  pulse: CP0 loads EPC from exc_epc_o.
- cp0_badv_we_o  out  1  pulse: CP0 loads BadVAddr from exc_badv_o.
- cp0_eret_o  out  1  pulse: CP0 clears EXL.
- exc_code_o  out  5  ExcCode.
- exc_bd_o  out  1  Cause.BD value.
- exc_epc_o  out  32  EPC value.
- exc_badv_o  out  32  BadVAddr value.
- flush_o  out  1  clear IF, ID, EX, MEM valid bits.
- redirect_o  out  1  fetch loads redirect_pc_o.
- redirect_pc_o  out  32  new fetch PC.
- busy_o  out  1  FSM not in IDLE.

## Operation
- Event candidate, evaluated only in IDLE with stall_i=0 and m_valid_i=1. Priority, highest first, with ExcCode: interrupt (0), AdEL fetch (4), RI (10), Ov (12), Sys (8), Bp (9), AdEL data (4), AdES data (5), eret (no code).
- kill_m_o=1 in the same cycle as any candidate, including eret. The instruction does not retire.
- Captured at the clock edge: code; bd=m_bd_i; epc = m_bd_i ? m_pc_i-4 : m_pc_i (32-bit wrap).
- badv: m_pc_i for AdEL fetch, m_daddr_i for AdEL/AdES data. cp0_badv_we_o is asserted only for these three.
- If exl_i=1 when captured, cp0_epc_we_o stays 0 and EPC is preserved. All other strobes assert as usual.
- FSM states:
  - IDLE → FIRE on candidate.
  - FIRE (one cycle): flush_o=1, redirect_o=1, strobes asserted. redirect_pc_o=EXC_VECTOR, or epc_i for eret. → DRAIN, counter=DRAIN_CYC-1.
  - DRAIN: decrement counter; inputs ignored. → IDLE when counter=0.
- An interrupt with m_valid_i=0 (bubble) waits until a valid instruction reaches MEM.
- eret with a simultaneous interrupt: the interrupt wins. EPC is written with the eret PC, and the eret is re-executed after the handler.
- eret carrying an exception flag: the exception wins.

## Timing
- Candidate in cycle N: kill_m_o high in cycle N; FIRE outputs high for exactly cycle N+1; IDLE re-entered at end of N+1+DRAIN_CYC.
- Minimum spacing between two events: 2+DRAIN_CYC cycles.
- stall_i high in IDLE: no candidate and kill_m_o=0. stall_i is ignored in FIRE/DRAIN; flush has priority over stall.
- All outputs except kill_m_o are registered.
- Reset values: state IDLE, all strobes/flush/redirect/busy 0, exc_code_o=0, exc_bd_o=0, exc_epc_o=0, exc_badv_o=0, redirect_pc_o=EXC_VECTOR.
- rst mid-FIRE or mid-DRAIN: immediate return to IDLE with reset values. No partial strobe is issued.

## Structure
- Shared package `mips_exc_pkg`: ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), EXC_VECTOR default, FSM state encoding.
- Sub-module `exc_prio_enc`: purely combinational priority encoder. Flags in; valid, code, badv_sel, is_eret out.

## Test plan
- Ov at m_pc_i=0xBFC0_0100, bd=0, exl=0 → kill_m in N; N+1: code=12, epc=0xBFC0_0100, epc_we=1, badv_we=0, redirect to 0xBFC0_0380.
- AdES with m_daddr_i=0x8000_0002, bd=1, m_pc_i=0xBFC0_0204 → code=5, bd=1, epc=0xBFC0_0200, badv=0x8000_0002.
- int_pending and m_sys_i together, m_valid_i=1 → code=0; no second event during the 2 DRAIN cycles even with m_sys_i held high.
- eret with epc_i=0xBFC0_1234 → cp0_eret pulse, redirect_pc=0xBFC0_1234, exc_we=0. Repeat with int_pending=1 → code=0, epc=eret PC.
- int_pending held with stall_i=1 for 3 cycles, then m_valid_i=0 for 2 cycles → no event. Event fires the first cycle stall_i=0 and m_valid_i=1.
- rst asserted during FIRE → all outputs 0 that cycle, busy_o=0, redirect_pc_o=0xBFC0_0380. Next candidate is handled normally.
